// File: rtl/interval_timer_ctrl_pkg.sv
// Shared types and constants for the interval timer controller.
//   state_e       : controller state encoding (IDLE, LOAD, RUN)
//   MODE_*        : run mode encoding captured with start
//   DEFAULT_WIDTH : default counter width in bits
package interval_timer_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/interval_timer_ctrl_if.sv
// Control/status bundle between a requester and the interval timer controller.
//   start, abort, mode, start_val, end_val : requester -> timer
//   count, busy, tick, done                : timer -> requester
interface interval_timer_ctrl_if
  import interval_timer_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic             abort;
  logic             mode;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] end_val;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tick;
  logic             done;

  modport master (
    output start, abort, mode, start_val, end_val,
    input  count, busy, tick, done
  );

  modport slave (
    input  start, abort, mode, start_val, end_val,
    output count, busy, tick, done
  );

endinterface

// File: rtl/interval_timer_ctrl_loadable_up_counter.sv
// Loadable free-running up-counter; priority is reset, then load, then +1.
//   clk      : clock
//   rst      : synchronous active-high reset to 0
//   ld       : load ld_value on the next edge
//   ld_value : value to load
//   y        : current count (wraps modulo 2^WIDTH)
module loadable_up_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_value,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] y_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= '0;
    end else if (ld) begin
      y_q <= ld_value;
    end else begin
      y_q <= y_q + WIDTH'(1);
    end
  end

  assign y = y_q;

endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer controller: sequences a loadable up-counter to produce
// one-shot or periodic terminal-count ticks.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : slave side of interval_timer_ctrl_if (start/abort/config in,
//         count/busy/tick/done out; tick and done are same-cycle pulses)
module interval_timer_ctrl
  import interval_timer_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  interval_timer_ctrl_if.slave  bus
);

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] end_q, end_d;

  logic             core_rst_c;
  logic             core_ld_c;
  logic             tick_c;
  logic             done_c;
  logic [WIDTH-1:0] core_y;

  loadable_up_counter #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (core_rst_c),
    .ld       (core_ld_c),
    .ld_value (start_q),
    .y        (core_y)
  );

  // State and captured configuration
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ONESHOT;
      start_q <= '0;
      end_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      start_q <= start_d;
      end_q   <= end_d;
    end
  end

  // Next-state, core control and event pulses
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    start_d   = start_q;
    end_d     = end_q;
    core_ld_c = 1'b0;
    tick_c    = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mode_d  = bus.mode;
          start_d = bus.start_val;
          end_d   = bus.end_val;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          core_ld_c = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        // abort beats a coincident terminal count
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if ((core_y == end_q) && !rst) begin
          tick_c = 1'b1;
          if (mode_q == MODE_PERIODIC) begin
            core_ld_c = 1'b1;
          end else begin
            done_c  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Park the core at 0 while idle and on every exit to idle, so count reads 0 in IDLE
  assign core_rst_c = rst || (state_q == ST_IDLE) || (state_d == ST_IDLE);

  assign bus.count = core_y;
  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.tick  = tick_c;
  assign bus.done  = done_c;

endmodule

// File: doc/interval_timer_ctrl.md
Name: interval_timer_ctrl

Overview:
- Controller that sequences a loadable up-counter core (sync reset, load over increment, free-running increment) to produce programmable one-shot or periodic terminal-count events.
- Drives the core's reset and load controls: parks it at 0 when idle, loads a start value, and watches for an end value.
- Sits between software/system control (start/abort/config) and any logic that needs cycle-accurate interval ticks.

Parameters:
- WIDTH, 4, counter width in bits; all value ports and arithmetic are WIDTH bits, modulo 2^WIDTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request to begin a run; sampled only in IDLE.
- abort  in  1  terminate the current run; sampled in LOAD and RUN.
- mode  in  1  0 = one-shot, 1 = periodic; captured with start.
- start_val  in  WIDTH  first count value; captured with start.
- end_val  in  WIDTH  terminal count value; captured with start.
- count  out  WIDTH  current counter core value.
- busy  out  1  high when state is not IDLE.
- tick  out  1  one-cycle pulse when count equals captured end in RUN.
- done  out  1  one-cycle pulse on the final tick of a one-shot run.

Behaviour:
- Reset: state IDLE, count 0, busy 0, tick 0, done 0, captured registers 0. Reset overrides every other input in the same cycle.
- States: IDLE, LOAD, RUN.
- IDLE:
  - Core held in reset (core rst = rst OR state==IDLE), so count = 0.
  - start=1 captures mode, start_val and end_val, then moves to LOAD at the next edge.
  - abort is ignored.
- LOAD:
  - Core ld=1 with ld_value = captured start, so count = start at the next edge; moves to RUN.
  - abort=1 returns to IDLE instead; the core is still reset back to 0.
- RUN:
  - Core ld=0 and the counter increments by 1 per cycle, wrapping 2^WIDTH-1 to 0.
  - tick is combinational: it is 1 when state==RUN AND count==end AND abort==0.
- On a tick, periodic mode:
  - Core ld=1 in the same cycle, so the next count is the captured start.
  - State stays RUN.
  - Period = ((end - start) mod 2^WIDTH) + 1 cycles.
- On a tick, one-shot mode:
  - done=1 in the same cycle.
  - State moves to IDLE at the next edge, and count becomes 0 the following cycle.
- abort in RUN:
  - Moves to IDLE at the next edge.
  - Wins over a coincident terminal count: no tick and no done in that cycle.
- start while busy is ignored; captured values are unchanged until the next IDLE acceptance.
- start held high across a one-shot completion is accepted in the first IDLE cycle. Minimum gap between done and the next LOAD is 1 IDLE cycle.
- Boundary cases:
  - end == start: tick on the first RUN cycle. In periodic mode tick stays high every cycle, with a reload each cycle.
  - end < start: the count wraps through 0, e.g. start=14, end=1 on WIDTH=4 gives a period of 4.
- Latency: start accepted in cycle n gives LOAD in n+1 and the first RUN cycle in n+2 with count = start.
- Config inputs are don't-care outside the start-acceptance cycle.

Decomposition:
- Shared package: state encoding enum (IDLE, LOAD, RUN) and mode constants (MODE_ONESHOT=0, MODE_PERIODIC=1).
- One sub-module, loadable_up_counter:
  - WIDTH-parameterised.
  - Ports clk, rst, ld, ld_value, y.
  - Priority: sync reset, then load, then increment.
- The controller FSM and compare logic stay in the top module.

Test Plan:
- Reset mid-RUN (start=3, end=9, assert rst when count=5) -> next cycle count=0, busy=0, tick=0; no done ever fires.
- One-shot, start=3, end=6, start pulsed in cycle 0 -> LOAD in cycle 1; count 3,4,5,6 in cycles 2-5; tick=done=1 in cycle 5 only; busy=0 and count=0 from cycle 6.
- Periodic, start=3, end=6 -> tick pulses every 4 cycles (cycles 5, 9, 13, ...); count sequence 3,4,5,6,3,...; done never asserts.
- Wrap, periodic, start=14, end=1 (WIDTH=4) -> count 14,15,0,1,14,...; tick period 4. Second case end=start=7 -> tick high every RUN cycle.
- Abort coincident with count==end in RUN -> tick=0 and done=0 that cycle, IDLE next cycle. Abort in LOAD -> RUN is never entered.
- start asserted while busy with different values -> ignored and the run completes with the original values. start held high through a one-shot done -> a new LOAD occurs exactly 2 cycles after done.
